// File: rtl/btb_pkg.sv
// btb_pkg: BTB geometry, update record, controller states and PC field helpers.
package btb_pkg;
    localparam int DATA_W     = 32;
    localparam int ENTRY_BITS = 3;
    localparam int ENTRIES    = 1 << ENTRY_BITS;
    localparam int TAG_BITS   = DATA_W - 2 - ENTRY_BITS;
    localparam int Q_DEPTH    = 4;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    typedef struct packed {
        logic [ENTRY_BITS-1:0] entry;
        logic [TAG_BITS-1:0]   tag;
        logic [DATA_W-1:0]     target;
        logic                  valid;
    } upd_t;

    localparam int UPD_W = $bits(upd_t);

    function automatic logic [ENTRY_BITS-1:0] pc_entry(input logic [DATA_W-1:0] pc);
        return pc[ENTRY_BITS+1:2];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [DATA_W-1:0] pc);
        return pc[DATA_W-1:ENTRY_BITS+2];
    endfunction
endpackage

// File: rtl/btb_update_fifo.sv
// btb_update_fifo: synchronous FIFO holding pending BTB update records.
module btb_update_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [UPD_W-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [UPD_W-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [UPD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + AW'(do_push);
            rptr_q  <= rptr_q + AW'(do_pop);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem_q[wptr_q] <= push_data_i;
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: resolves EX branches, redirects on mispredict and arbitrates the BTB write port.
module btb_update_ctrl
    import btb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Ex_Valid,
    input  logic [DATA_W-1:0]     PC_Ex,
    input  logic                  Ex_Taken,
    input  logic [DATA_W-1:0]     Ex_Target,
    input  logic                  Ex_Pred_Hit,
    input  logic [DATA_W-1:0]     Ex_Pred_Target,
    input  logic                  Inv_Req,
    input  logic [ENTRY_BITS-1:0] Inv_Entry,
    output logic                  Inv_Ack,
    output logic                  Stall_Ex,
    output logic                  Redirect,
    output logic [DATA_W-1:0]     Redirect_PC,
    output logic                  Wr_En,
    output logic [ENTRY_BITS-1:0] Wr_Entry,
    output logic [TAG_BITS-1:0]   Wr_Tag,
    output logic [DATA_W-1:0]     Wr_Target,
    output logic                  Wr_Valid,
    output logic                  Ready,
    output logic [15:0]           Mispred_Cnt
);
    localparam int CW = $clog2(Q_DEPTH);

    state_t                state_q, state_d;
    logic [ENTRY_BITS:0]   idx_q, idx_d;
    logic                  stall_q, stall_d, ack_q, ack_d, redir_q, redir_d;
    logic [DATA_W-1:0]     redir_pc_q, redir_pc_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d, wr_valid_q, wr_valid_d;
    logic [ENTRY_BITS-1:0] wr_entry_q, wr_entry_d;
    logic [TAG_BITS-1:0]   wr_tag_q, wr_tag_d;
    logic [DATA_W-1:0]     wr_target_q, wr_target_d;
    logic                  run, qual, mispred, enq, pop, full, empty;
    logic [CW:0]           count, count_nx;
    upd_t                  enq_rec, head;

    assign run     = state_q == RUN;
    assign qual    = run && Ex_Valid && !stall_q;
    assign mispred = (Ex_Taken != Ex_Pred_Hit) || (Ex_Taken && Ex_Pred_Hit && Ex_Target != Ex_Pred_Target);
    // Every mispredict needs exactly one BTB update, so the enqueue rule coincides with it.
    assign enq     = qual && mispred;
    assign pop     = run && !Inv_Req && !empty;
    assign enq_rec = '{entry: pc_entry(PC_Ex), tag: pc_tag(PC_Ex), target: Ex_Taken ? Ex_Target : '0, valid: Ex_Taken};
    assign count_nx = count + (CW+1)'(enq) - (CW+1)'(pop);

    btb_update_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (enq),
        .push_data_i(enq_rec),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_en_d     = 1'b0;
        wr_entry_d  = wr_entry_q;
        wr_tag_d    = wr_tag_q;
        wr_target_d = wr_target_q;
        wr_valid_d  = wr_valid_q;
        if (!run) begin
            if (idx_q[ENTRY_BITS]) begin
                state_d = RUN;
            end else begin
                wr_en_d     = 1'b1;
                wr_entry_d  = idx_q[ENTRY_BITS-1:0];
                wr_tag_d    = '0;
                wr_target_d = '0;
                wr_valid_d  = 1'b0;
                idx_d       = idx_q + 1'b1;
            end
        end else if (Inv_Req) begin
            wr_en_d     = 1'b1;
            wr_entry_d  = Inv_Entry;
            wr_tag_d    = '0;
            wr_target_d = '0;
            wr_valid_d  = 1'b0;
        end else if (!empty) begin
            wr_en_d     = 1'b1;
            wr_entry_d  = head.entry;
            wr_tag_d    = head.tag;
            wr_target_d = head.target;
            wr_valid_d  = head.valid;
        end
        ack_d      = run && Inv_Req;
        stall_d    = state_d == INIT || count_nx == (CW+1)'(Q_DEPTH);
        redir_d    = enq;
        redir_pc_d = enq ? (Ex_Taken ? Ex_Target : PC_Ex + DATA_W'(4)) : redir_pc_q;
        cnt_d      = (enq && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INIT;
            idx_q       <= '0;
            stall_q     <= 1'b0;
            ack_q       <= 1'b0;
            redir_q     <= 1'b0;
            redir_pc_q  <= '0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_entry_q  <= '0;
            wr_tag_q    <= '0;
            wr_target_q <= '0;
            wr_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stall_q     <= stall_d;
            ack_q       <= ack_d;
            redir_q     <= redir_d;
            redir_pc_q  <= redir_pc_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_entry_q  <= wr_entry_d;
            wr_tag_q    <= wr_tag_d;
            wr_target_q <= wr_target_d;
            wr_valid_q  <= wr_valid_d;
        end
    end

    assign Ready       = run;
    assign Stall_Ex    = stall_q;
    assign Inv_Ack     = ack_q;
    assign Redirect    = redir_q;
    assign Redirect_PC = redir_pc_q;
    assign Mispred_Cnt = cnt_q;
    assign Wr_En       = wr_en_q;
    assign Wr_Entry    = wr_entry_q;
    assign Wr_Tag      = wr_tag_q;
    assign Wr_Target   = wr_target_q;
    assign Wr_Valid    = wr_valid_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed checks of sweep, mispredict redirect, FIFO arbitration and reset.
module tb_btb_update_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        Ex_Valid, Ex_Taken, Ex_Pred_Hit, Inv_Req;
    logic [31:0] PC_Ex, Ex_Target, Ex_Pred_Target;
    logic [2:0]  Inv_Entry;
    logic        Inv_Ack, Stall_Ex, Redirect, Wr_En, Wr_Valid, Ready;
    logic [31:0] Redirect_PC, Wr_Target;
    logic [2:0]  Wr_Entry;
    logic [26:0] Wr_Tag;
    logic [15:0] Mispred_Cnt;
    int checks = 0;
    int errors = 0;

    btb_update_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Ex_Valid(Ex_Valid), .PC_Ex(PC_Ex), .Ex_Taken(Ex_Taken),
        .Ex_Target(Ex_Target), .Ex_Pred_Hit(Ex_Pred_Hit), .Ex_Pred_Target(Ex_Pred_Target),
        .Inv_Req(Inv_Req), .Inv_Entry(Inv_Entry), .Inv_Ack(Inv_Ack), .Stall_Ex(Stall_Ex),
        .Redirect(Redirect), .Redirect_PC(Redirect_PC), .Wr_En(Wr_En), .Wr_Entry(Wr_Entry),
        .Wr_Tag(Wr_Tag), .Wr_Target(Wr_Target), .Wr_Valid(Wr_Valid), .Ready(Ready),
        .Mispred_Cnt(Mispred_Cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic branch(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic hit, input logic [31:0] ptgt);
        Ex_Valid = 1'b1; PC_Ex = pc; Ex_Taken = tk; Ex_Target = tgt;
        Ex_Pred_Hit = hit; Ex_Pred_Target = ptgt;
    endtask

    task automatic chk_wr(input string tag, input logic [2:0] e, input logic [26:0] t,
                          input logic [31:0] tgt, input logic v);
        chk({tag, "_en"}, 32'(Wr_En), 32'd1);
        chk({tag, "_entry"}, 32'(Wr_Entry), 32'(e));
        chk({tag, "_tag"}, 32'(Wr_Tag), 32'(t));
        chk({tag, "_tgt"}, Wr_Target, tgt);
        chk({tag, "_valid"}, 32'(Wr_Valid), 32'(v));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_wr(tag, 3'(i), 27'd0, 32'd0, 1'b0);
            chk({tag, "_stall"}, 32'(Stall_Ex), 32'd1);
            chk({tag, "_ready"}, 32'(Ready), 32'd0);
            chk({tag, "_ack"}, 32'(Inv_Ack), 32'd0);
        end
        tick();
        chk({tag, "_ready9"}, 32'(Ready), 32'd1);
        chk({tag, "_stall9"}, 32'(Stall_Ex), 32'd0);
        chk({tag, "_wren9"}, 32'(Wr_En), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; Ex_Valid = 1'b0; PC_Ex = '0; Ex_Taken = 1'b0; Ex_Target = '0;
        Ex_Pred_Hit = 1'b0; Ex_Pred_Target = '0; Inv_Req = 1'b0; Inv_Entry = '0;
        tick(); tick();
        chk("rst_ready", 32'(Ready), 32'd0);
        chk("rst_redir", 32'(Redirect), 32'd0);
        chk("rst_rpc", Redirect_PC, 32'd0);
        chk("rst_ack", 32'(Inv_Ack), 32'd0);
        chk("rst_stall", 32'(Stall_Ex), 32'd0);
        chk("rst_cnt", 32'(Mispred_Cnt), 32'd0);
        chk("rst_wren", 32'(Wr_En), 32'd0);
        rst_n = 1'b1;
        // INIT ignores EX traffic
        branch(32'h100, 1'b1, 32'h240, 1'b0, 32'h0);
        sweep("init");
        chk("init_cnt", 32'(Mispred_Cnt), 32'd0);

        // taken miss
        tick();
        Ex_Valid = 1'b0;
        chk("tm_redir", 32'(Redirect), 32'd1);
        chk("tm_rpc", Redirect_PC, 32'h240);
        chk("tm_cnt", 32'(Mispred_Cnt), 32'd1);
        chk("tm_wr_early", 32'(Wr_En), 32'd0);
        tick();
        chk("tm_redir_off", 32'(Redirect), 32'd0);
        chk_wr("tm_wr", 3'd0, 27'h8, 32'h240, 1'b1);

        // not-taken false hit
        branch(32'h11C, 1'b0, 32'h300, 1'b1, 32'h200);
        tick();
        Ex_Valid = 1'b0;
        chk("nt_redir", 32'(Redirect), 32'd1);
        chk("nt_rpc", Redirect_PC, 32'h120);
        chk("nt_cnt", 32'(Mispred_Cnt), 32'd2);
        tick();
        chk_wr("nt_wr", 3'd7, 27'h8, 32'h0, 1'b0);

        // correct taken prediction
        branch(32'h180, 1'b1, 32'h400, 1'b1, 32'h400);
        tick();
        branch(32'h184, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        Ex_Valid = 1'b0;
        chk("ok_redir", 32'(Redirect), 32'd0);
        chk("ok_cnt", 32'(Mispred_Cnt), 32'd2);
        chk("ok_wren", 32'(Wr_En), 32'd0);
        tick();
        chk("ok_wren2", 32'(Wr_En), 32'd0);
        chk("ok_rpc_hold", Redirect_PC, 32'h120);

        // taken hit, wrong target
        branch(32'h1A4, 1'b1, 32'h500, 1'b1, 32'h400);
        tick();
        Ex_Valid = 1'b0;
        chk("wt_redir", 32'(Redirect), 32'd1);
        chk("wt_rpc", Redirect_PC, 32'h500);
        chk("wt_cnt", 32'(Mispred_Cnt), 32'd3);
        tick();
        chk_wr("wt_wr", 3'd1, 27'hD, 32'h500, 1'b1);

        // PC+4 wraps at the top of the address space
        branch(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
        tick();
        Ex_Valid = 1'b0;
        chk("wrap_rpc", Redirect_PC, 32'h0);
        chk("wrap_cnt", 32'(Mispred_Cnt), 32'd4);
        tick();
        chk_wr("wrap_wr", 3'd7, 27'h7FF_FFFF, 32'h0, 1'b0);

        // invalidate wins while the FIFO fills
        Inv_Req = 1'b1; Inv_Entry = 3'd3;
        tick();
        chk("inv_ack", 32'(Inv_Ack), 32'd1);
        chk_wr("inv_wr", 3'd3, 27'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            branch(32'h200 + 32'(4 * i), 1'b1, 32'h1000 + 32'(16 * i), 1'b0, 32'h0);
            tick();
            chk("fill_ack", 32'(Inv_Ack), 32'd1);
            chk("fill_entry", 32'(Wr_Entry), 32'd3);
            chk("fill_valid", 32'(Wr_Valid), 32'd0);
            chk("fill_stall", 32'(Stall_Ex), 32'(i == 3));
        end
        branch(32'h210, 1'b1, 32'h1040, 1'b0, 32'h0);
        tick();
        chk("held_stall", 32'(Stall_Ex), 32'd1);
        chk("held_cnt", 32'(Mispred_Cnt), 32'd8);
        tick();
        chk("held_redir", 32'(Redirect), 32'd0);
        chk("held_stall2", 32'(Stall_Ex), 32'd1);
        chk("held_entry", 32'(Wr_Entry), 32'd3);
        chk("held_cnt2", 32'(Mispred_Cnt), 32'd8);
        Inv_Req = 1'b0;
        tick();
        chk("drain0_ack", 32'(Inv_Ack), 32'd0);
        chk("drain0_stall", 32'(Stall_Ex), 32'd0);
        chk_wr("drain0", 3'd0, 27'h10, 32'h1000, 1'b1);
        tick();
        Ex_Valid = 1'b0;
        chk_wr("drain1", 3'd1, 27'h10, 32'h1010, 1'b1);
        chk("fifth_redir", 32'(Redirect), 32'd1);
        chk("fifth_rpc", Redirect_PC, 32'h1040);
        chk("fifth_cnt", 32'(Mispred_Cnt), 32'd9);
        for (int i = 2; i < 5; i++) begin
            tick();
            chk_wr("drain", 3'(i), 27'h10, 32'h1000 + 32'(16 * i), 1'b1);
        end
        tick();
        chk("drained_wren", 32'(Wr_En), 32'd0);
        chk("drained_stall", 32'(Stall_Ex), 32'd0);

        // queue updates behind an invalidate, then reset mid-sweep
        Inv_Req = 1'b1; Inv_Entry = 3'd5;
        branch(32'h300, 1'b1, 32'h2000, 1'b0, 32'h0);
        tick();
        branch(32'h304, 1'b1, 32'h2004, 1'b0, 32'h0);
        tick();
        Ex_Valid = 1'b0;
        chk("pend_entry", 32'(Wr_Entry), 32'd5);
        chk("pend_cnt", 32'(Mispred_Cnt), 32'd11);
        rst_n = 1'b0;
        tick();
        chk("rst2_cnt", 32'(Mispred_Cnt), 32'd0);
        chk("rst2_wren", 32'(Wr_En), 32'd0);
        chk("rst2_ready", 32'(Ready), 32'd0);
        chk("rst2_ack", 32'(Inv_Ack), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("part_entry", 32'(Wr_Entry), 32'(i));
        end
        rst_n = 1'b0;
        tick();
        chk("rst3_wren", 32'(Wr_En), 32'd0);
        rst_n = 1'b1;
        sweep("resweep");
        tick();
        chk("post_ack", 32'(Inv_Ack), 32'd1);
        chk_wr("post_inv", 3'd5, 27'd0, 32'd0, 1'b0);
        Inv_Req = 1'b0;
        tick();
        chk("post_wren", 32'(Wr_En), 32'd0);
        chk("post_ack_off", 32'(Inv_Ack), 32'd0);
        tick();
        chk("post_wren2", 32'(Wr_En), 32'd0);
        chk("post_cnt", 32'(Mispred_Cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Controller for the pipeline's direct-mapped branch target buffer (BTB).
- Resolves EX-stage branches against the IF-stage prediction and issues registered redirect/flush on mispredict.
- Buffers required BTB updates in a small FIFO and arbitrates the single BTB write port between three sources: the post-reset invalidation sweep, external invalidate requests and queued updates.
- Sits between the EX stage, the fetch PC mux and the BTB write port.

Parameters:
- DATA_W, 32, PC/target width.
- ENTRY_BITS, 3, BTB index width (PC[ENTRY_BITS+1:2]); ENTRIES = 1<<ENTRY_BITS.
- TAG_BITS, DATA_W-2-ENTRY_BITS, tag width (PC[DATA_W-1:ENTRY_BITS+2]).
- Q_DEPTH, 4, update FIFO depth (power of two).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- Ex_Valid  in  1  a resolved branch/jump is in EX this cycle.
- PC_Ex  in  DATA_W  PC of the EX branch.
- Ex_Taken  in  1  actual outcome.
- Ex_Target  in  DATA_W  actual target (ALU result).
- Ex_Pred_Hit  in  1  BTB hit recorded at fetch (predicted taken).
- Ex_Pred_Target  in  DATA_W  predicted target recorded at fetch.
- Inv_Req  in  1  request to invalidate entry Inv_Entry; level, held until Inv_Ack.
- Inv_Entry  in  ENTRY_BITS  entry to invalidate.
- Inv_Ack  out  1  one-cycle pulse when the invalidate write is issued.
- Stall_Ex  out  1  update FIFO full; EX must hold.
- Redirect  out  1  one-cycle mispredict pulse.
- Redirect_PC  out  DATA_W  correct fetch PC.
- Wr_En  out  1  BTB write strobe.
- Wr_Entry  out  ENTRY_BITS  BTB write index.
- Wr_Tag  out  TAG_BITS  tag to write.
- Wr_Target  out  DATA_W  target to write.
- Wr_Valid  out  1  valid bit to write.
- Ready  out  1  init sweep complete.
- Mispred_Cnt  out  16  saturating mispredict counter.

Behaviour:
- Reset: state INIT, sweep index 0, FIFO empty.
  - Outputs: Ready=0, Redirect=0, Redirect_PC=0, Inv_Ack=0, Stall_Ex=0, Mispred_Cnt=0.
  - Wr_En is 1 from the first cycle after reset (INIT sweep, below).
  - Reset asserted mid-sweep or mid-operation restarts INIT from index 0 and discards FIFO contents.
- FSM INIT:
  - Writes Wr_Valid=0, Wr_Tag=0, Wr_Target=0 to entry index, one entry per cycle.
  - After index ENTRIES-1 is written, moves to RUN and sets Ready=1.
  - Sweep takes exactly ENTRIES cycles.
- INIT input handling:
  - Ex_Valid is ignored.
  - Stall_Ex=1 throughout INIT.
  - Inv_Req stays pending and is not acked during INIT.
- Mispredict (RUN only, evaluated when Ex_Valid && !Stall_Ex):
  - mispredict = (Ex_Taken != Ex_Pred_Hit) || (Ex_Taken && Ex_Pred_Hit && Ex_Target != Ex_Pred_Target).
  - Redirect is registered: it pulses the cycle after the EX cycle.
  - Redirect_PC = Ex_Taken ? Ex_Target : PC_Ex+4, computed modulo 2^DATA_W.
  - Mispred_Cnt increments on each mispredict and saturates at 16'hFFFF.
- Enqueue rules (same qualifier as mispredict):
  - Taken and (!Ex_Pred_Hit or target differs): enqueue {entry, tag, Ex_Target, valid=1}.
  - Not taken with Ex_Pred_Hit: enqueue {entry, tag, 0, valid=0}.
  - All other cases: no enqueue.
- FIFO:
  - Stall_Ex = INIT || count==Q_DEPTH, from registered count.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Pointers wrap modulo Q_DEPTH.
  - An enqueue in cycle N is writable no earlier than cycle N+1.
- Write-port arbitration, at most one write per cycle; priority INIT sweep > Inv_Req > FIFO head.
  - Inv_Req granted: Wr_Valid=0 to Inv_Entry, Inv_Ack=1 the same cycle, FIFO does not drain that cycle.
  - FIFO head granted: entry is popped.
- Write-port timing: Wr_* outputs are registered and valid in the cycle Wr_En=1; Wr_* fields hold their last value when Wr_En=0.
- Same-entry conflicts are resolved in write order; no coalescing.

Decomposition:
- Shared package btb_pkg:
  - DATA_W, ENTRY_BITS, TAG_BITS.
  - Update-record struct {entry, tag, target, valid}.
  - FSM state enum {INIT, RUN}.
  - Entry/tag extraction functions, shared with the BTB.
- One sub-module: btb_update_fifo, a parameterised synchronous FIFO (push/pop/full/empty/count) holding update records.

Test Plan:
- Reset then idle:
  - Wr_En=1 for exactly 8 cycles with Wr_Entry 0..7 and Wr_Valid=0.
  - Ready rises on cycle 9; Stall_Ex=1 until then.
- Taken miss:
  - Stimulus: PC_Ex=0x100, Ex_Taken=1, Ex_Target=0x240, Ex_Pred_Hit=0.
  - Next cycle: Redirect=1, Redirect_PC=0x240, Mispred_Cnt=1.
  - Then a write with Wr_Entry=0, Wr_Tag=0x100>>5, Wr_Target=0x240, Wr_Valid=1.
- Not-taken false hit:
  - Stimulus: PC_Ex=0x11C, Ex_Pred_Hit=1, Ex_Taken=0.
  - Response: Redirect_PC=0x120, then a write to entry 7 with Wr_Valid=0.
- Correct prediction:
  - Stimulus: Ex_Taken=1, Ex_Pred_Hit=1, Ex_Pred_Target=Ex_Target.
  - Response: no Redirect, no write, counter unchanged.
- FIFO full:
  - Stimulus: hold Inv_Req=1 (entry 3), then issue 5 back-to-back taken-miss branches.
  - Only invalidate writes occur; Inv_Ack pulses, and the FIFO stays undrained only while Inv_Req wins arbitration.
  - After 4 enqueues, Stall_Ex=1 and the 5th is held.
  - Drop Inv_Req; FIFO drains in order, one write per cycle, and Stall_Ex falls after the first pop.
- Reset mid-sweep:
  - Stimulus: assert rst_n=0 at sweep index 4.
  - Response: sweep restarts at entry 0, Mispred_Cnt=0, pending FIFO entries are never written.
